// File: rtl/branch_pred_table_if.sv
// Lookup/update port bundle for branch_pred_table.
// master = fetch/resolve side, slave = predictor table.
interface branch_pred_table_if #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned IDX_W = 6
);
   logic             lkp_valid;
   logic [PC_W-1:0]  lkp_pc;
   logic             pred_valid;
   logic             pred_taken;
   logic             pred_strong;
   logic [IDX_W-1:0] pred_hist;
   logic             upd_valid;
   logic [PC_W-1:0]  upd_pc;
   logic [IDX_W-1:0] upd_hist;
   logic             upd_taken;
   logic [IDX_W-1:0] ghr;

   modport master (
      output lkp_valid, lkp_pc, upd_valid, upd_pc, upd_hist, upd_taken,
      input  pred_valid, pred_taken, pred_strong, pred_hist, ghr
   );

   modport slave (
      input  lkp_valid, lkp_pc, upd_valid, upd_pc, upd_hist, upd_taken,
      output pred_valid, pred_taken, pred_strong, pred_hist, ghr
   );
endinterface

// File: rtl/branch_pred_table.sv
// Branch-direction predictor: 2**IDX_W saturating counters, bimodal (MODE 0)
// or gshare (MODE 1) indexing, 1-cycle registered lookup, single update port.
module branch_pred_table #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned IDX_W = 6,
   parameter int unsigned CNT_W = 2,
   parameter int unsigned MODE  = 0
) (
   input logic               clk,
   input logic               rst,
   branch_pred_table_if.slave bp
);
   localparam int unsigned      Entries = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntInit = CNT_W'(1) << (CNT_W - 1);

   logic [CNT_W-1:0] r_cnt [Entries];
   logic [IDX_W-1:0] r_ghr;
   logic             r_pred_valid;
   logic             r_pred_taken;
   logic             r_pred_strong;
   logic [IDX_W-1:0] r_pred_hist;

   logic [IDX_W-1:0] w_lkp_hist;
   logic [IDX_W-1:0] w_upd_hist;
   logic [IDX_W-1:0] w_lkp_idx;
   logic [IDX_W-1:0] w_upd_idx;
   logic [CNT_W-1:0] w_lkp_cnt;
   logic [CNT_W-1:0] w_upd_cnt;
   logic [CNT_W-1:0] w_upd_cnt_nxt;
   logic [IDX_W-1:0] w_ghr_nxt;
   logic             w_unused;

   assign w_lkp_hist = (MODE == 1) ? r_ghr : '0;
   assign w_upd_hist = (MODE == 1) ? bp.upd_hist : '0;
   assign w_lkp_idx  = bp.lkp_pc[IDX_W+1:2] ^ w_lkp_hist;
   assign w_upd_idx  = bp.upd_pc[IDX_W+1:2] ^ w_upd_hist;
   assign w_lkp_cnt  = r_cnt[w_lkp_idx];
   assign w_upd_cnt  = r_cnt[w_upd_idx];

   // Shift form also covers IDX_W == 1, where the new history is just upd_taken.
   assign w_ghr_nxt = (MODE == 1) ? ((r_ghr << 1) | IDX_W'(bp.upd_taken)) : '0;

   always_comb begin
      w_upd_cnt_nxt = w_upd_cnt;
      if (bp.upd_taken) begin
         if (w_upd_cnt != CntMax) w_upd_cnt_nxt = w_upd_cnt + 1'b1;
      end else begin
         if (w_upd_cnt != '0) w_upd_cnt_nxt = w_upd_cnt - 1'b1;
      end
   end

   // Lookup reads the pre-edge array, so a same-index update is read-before-write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(Entries); i++) r_cnt[i] <= CntInit;
         r_ghr         <= '0;
         r_pred_valid  <= 1'b0;
         r_pred_taken  <= 1'b0;
         r_pred_strong <= 1'b0;
         r_pred_hist   <= '0;
      end else begin
         r_pred_valid <= bp.lkp_valid;
         if (bp.lkp_valid) begin
            r_pred_taken  <= w_lkp_cnt[CNT_W-1];
            r_pred_strong <= (w_lkp_cnt == '0) || (w_lkp_cnt == CntMax);
            r_pred_hist   <= w_lkp_hist;
         end
         if (bp.upd_valid) begin
            r_cnt[w_upd_idx] <= w_upd_cnt_nxt;
            r_ghr            <= w_ghr_nxt;
         end
      end
   end

   assign bp.pred_valid  = r_pred_valid;
   assign bp.pred_taken  = r_pred_taken;
   assign bp.pred_strong = r_pred_strong;
   assign bp.pred_hist   = r_pred_hist;
   assign bp.ghr         = r_ghr;

   assign w_unused = ^{bp.lkp_pc[PC_W-1:IDX_W+2], bp.lkp_pc[1:0],
                       bp.upd_pc[PC_W-1:IDX_W+2], bp.upd_pc[1:0]};
endmodule

// File: tb/tb_branch_pred_table.sv
// Bench for branch_pred_table: bimodal and gshare instances share one stimulus
// stream and are checked against an integer-arithmetic reference model.
module tb_branch_pred_table;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_pred_table_if #(.PC_W(32), .IDX_W(6)) bif0 ();
   branch_pred_table_if #(.PC_W(32), .IDX_W(6)) bif1 ();

   branch_pred_table #(.PC_W(32), .IDX_W(6), .CNT_W(2), .MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .bp(bif0));
   branch_pred_table #(.PC_W(32), .IDX_W(6), .CNT_W(2), .MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .bp(bif1));

   int checks = 0;
   int errors = 0;

   // Reference state: counters as plain integers 0..3, history as an integer.
   int m_cnt [2][64];
   int m_ghr [2];
   int e_pv [2];
   int e_pt [2];
   int e_ps [2];
   int e_ph [2];

   typedef struct {
      logic        r;
      logic        lv;
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic        pv;
      logic        pt;
      logic        ps;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic lv, input logic [31:0] lpc,
                             input logic uv, input logic [31:0] upc,
                             input logic [5:0] uh, input logic ut);
      for (int m = 0; m < 2; m++) begin
         int li;
         int ui;
         int c;
         if (r) begin
            for (int k = 0; k < 64; k++) m_cnt[m][k] = 2;
            m_ghr[m] = 0;
            e_pv[m] = 0; e_pt[m] = 0; e_ps[m] = 0; e_ph[m] = 0;
         end else begin
            li = ((lpc >> 2) % 64) ^ (m == 1 ? m_ghr[m] : 0);
            ui = ((upc >> 2) % 64) ^ (m == 1 ? int'(uh) : 0);
            e_pv[m] = lv ? 1 : 0;
            if (lv) begin
               c = m_cnt[m][li];
               e_pt[m] = (c >= 2) ? 1 : 0;
               e_ps[m] = (c == 0 || c == 3) ? 1 : 0;
               e_ph[m] = (m == 1) ? m_ghr[m] : 0;
            end
            if (uv) begin
               c = m_cnt[m][ui];
               m_cnt[m][ui] = ut ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
               if (m == 1) m_ghr[m] = (m_ghr[m] * 2 + (ut ? 1 : 0)) % 64;
            end
         end
      end
   endtask

   task automatic check_model();
      chk("m0 pred_valid",  {31'd0, bif0.pred_valid},  e_pv[0]);
      chk("m0 pred_taken",  {31'd0, bif0.pred_taken},  e_pt[0]);
      chk("m0 pred_strong", {31'd0, bif0.pred_strong}, e_ps[0]);
      chk("m0 pred_hist",   {26'd0, bif0.pred_hist},   e_ph[0]);
      chk("m0 ghr",         {26'd0, bif0.ghr},         m_ghr[0]);
      chk("m1 pred_valid",  {31'd0, bif1.pred_valid},  e_pv[1]);
      chk("m1 pred_taken",  {31'd0, bif1.pred_taken},  e_pt[1]);
      chk("m1 pred_strong", {31'd0, bif1.pred_strong}, e_ps[1]);
      chk("m1 pred_hist",   {26'd0, bif1.pred_hist},   e_ph[1]);
      chk("m1 ghr",         {26'd0, bif1.ghr},         m_ghr[1]);
   endtask

   task automatic step(input logic r, input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc,
                       input logic [5:0] uh, input logic ut);
      rst = r;
      bif0.lkp_valid = lv; bif0.lkp_pc = lpc; bif0.upd_valid = uv;
      bif0.upd_pc = upc;   bif0.upd_hist = uh; bif0.upd_taken = ut;
      bif1.lkp_valid = lv; bif1.lkp_pc = lpc; bif1.upd_valid = uv;
      bif1.upd_pc = upc;   bif1.upd_hist = uh; bif1.upd_taken = ut;
      @(posedge clk);
      model_edge(r, lv, lpc, uv, upc, uh, ut);
      #1;
      check_model();
   endtask

   function automatic vec_t mk(input logic r, input logic lv, input logic [31:0] lpc,
                               input logic uv, input logic [31:0] upc, input logic ut,
                               input logic pv, input logic pt, input logic ps);
      vec_t v;
      v.r = r; v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut;
      v.pv = pv; v.pt = pt; v.ps = ps;
      return v;
   endfunction

   initial begin
      // Bimodal expectations, derived by hand from the counter rules.
      vecs[0]  = mk(1, 1, 32'h40,  1, 32'h40, 1, 0, 0, 0);  // reset ignores requests
      vecs[1]  = mk(0, 1, 32'h40,  0, 32'h0,  0, 1, 1, 0);  // weakly taken
      vecs[2]  = mk(0, 0, 32'h0,   1, 32'h40, 0, 0, 1, 0);  // 10->01, outputs hold
      vecs[3]  = mk(0, 0, 32'h0,   1, 32'h40, 0, 0, 1, 0);  // 01->00
      vecs[4]  = mk(0, 0, 32'h0,   1, 32'h40, 0, 0, 1, 0);  // stays 00
      vecs[5]  = mk(0, 1, 32'h40,  0, 32'h0,  0, 1, 0, 1);  // strong not-taken
      vecs[6]  = mk(0, 0, 32'h0,   1, 32'h40, 1, 0, 0, 1);  // 00->01
      vecs[7]  = mk(0, 0, 32'h0,   1, 32'h40, 1, 0, 0, 1);  // 01->10
      vecs[8]  = mk(0, 0, 32'h0,   1, 32'h40, 1, 0, 0, 1);  // 10->11
      vecs[9]  = mk(0, 0, 32'h0,   1, 32'h40, 1, 0, 0, 1);  // stays 11
      vecs[10] = mk(0, 1, 32'h140, 0, 32'h0,  0, 1, 1, 1);  // alias of 0x40
      vecs[11] = mk(0, 0, 32'h0,   1, 32'h80, 1, 0, 1, 1);  // 10->11
      vecs[12] = mk(0, 0, 32'h0,   1, 32'h80, 1, 0, 1, 1);  // stays 11
      vecs[13] = mk(0, 1, 32'h80,  1, 32'h80, 0, 1, 1, 1);  // read-before-write
      vecs[14] = mk(0, 1, 32'h80,  0, 32'h0,  0, 1, 1, 0);  // update landed: 10
      vecs[15] = mk(0, 0, 32'h0,   0, 32'h0,  0, 0, 1, 0);

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].r, vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, 6'd0, vecs[i].ut);
         chk($sformatf("vec%0d pred_valid", i),  {31'd0, bif0.pred_valid},  {31'd0, vecs[i].pv});
         chk($sformatf("vec%0d pred_taken", i),  {31'd0, bif0.pred_taken},  {31'd0, vecs[i].pt});
         chk($sformatf("vec%0d pred_strong", i), {31'd0, bif0.pred_strong}, {31'd0, vecs[i].ps});
      end

      // Gshare: train entry 0x15 via upd_hist, then build ghr = 0b000101.
      step(1, 0, 32'h0, 0, 32'h0,  6'd0, 0);
      step(0, 0, 32'h0, 1, 32'h40, 6'h05, 0);
      step(0, 0, 32'h0, 1, 32'h40, 6'h05, 0);
      step(0, 0, 32'h0, 1, 32'h0,  6'h00, 1);
      step(0, 0, 32'h0, 1, 32'h0,  6'h00, 0);
      step(0, 0, 32'h0, 1, 32'h0,  6'h00, 1);
      chk("gshare ghr", {26'd0, bif1.ghr}, 32'h05);
      step(0, 1, 32'h40, 0, 32'h0, 6'h00, 0);
      chk("gshare hist",   {26'd0, bif1.pred_hist},   32'h05);
      chk("gshare taken",  {31'd0, bif1.pred_taken},  32'h0);
      chk("gshare strong", {31'd0, bif1.pred_strong}, 32'h1);
      step(0, 1, 32'h54, 0, 32'h0, 6'h00, 0);  // idx 0x15^0x05 = 0x10, untouched
      chk("gshare other taken",  {31'd0, bif1.pred_taken},  32'h1);
      chk("gshare other strong", {31'd0, bif1.pred_strong}, 32'h0);

      // Reset while lookups and updates are streaming.
      for (int i = 0; i < 6; i++)
         step(0, 1, $urandom, 1, $urandom, 6'($urandom), 1'($urandom));
      step(1, 1, $urandom, 1, $urandom, 6'($urandom), 1'($urandom));
      chk("rst m0 pred_valid", {31'd0, bif0.pred_valid}, 32'h0);
      chk("rst m1 pred_valid", {31'd0, bif1.pred_valid}, 32'h0);
      chk("rst m1 ghr",        {26'd0, bif1.ghr},        32'h0);
      for (int k = 0; k < 64; k++) begin
         step(0, 1, 32'(k * 4), 0, 32'h0, 6'd0, 0);
         chk($sformatf("rst entry%0d m0", k), {30'd0, bif0.pred_taken, bif0.pred_strong}, 32'h2);
         chk($sformatf("rst entry%0d m1", k), {30'd0, bif1.pred_taken, bif1.pred_strong}, 32'h2);
      end

      // Random traffic against the model; narrow PCs to force index collisions.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] lpc;
         logic [31:0] upc;
         logic [5:0]  uh;
         lpc = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 15), 2'b00};
         upc = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 15), 2'b00};
         uh  = ($urandom_range(0, 1) == 0) ? 6'(e_ph[1]) : 6'($urandom);
         step(($urandom_range(0, 63) == 0), 1'($urandom), lpc, 1'($urandom), upc, uh,
              1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
